// File: rtl/mmu_address_translator.sv
// Single-request MMU: fully-associative TLB lookup with direct-mapped upper 1 GiB window.
// One translation in flight; result is held until the consumer accepts it.
module mmu_address_translator #(
    parameter int unsigned TLB_ENTRIES = 32
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        requestValid,
    output logic        requestReady,
    input  logic [31:0] virtualAddress,
    input  logic        requestWrite,
    output logic        responseValid,
    input  logic        responseReady,
    output logic [31:0] physicalAddress,
    output logic [1:0]  fault,
    input  logic        tlbWriteEnable,
    input  logic [4:0]  tlbWriteIndex,
    input  logic [19:0] tlbWritePage,
    input  logic [17:0] tlbWriteFrame,
    input  logic        tlbWriteWritable,
    input  logic        tlbWriteValid
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_e;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_MISS    = 2'd1;
    localparam logic [1:0] FLT_INVALID = 2'd2;
    localparam logic [1:0] FLT_WPROT   = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] va_q, va_d;
    logic        wr_q, wr_d;
    logic [31:0] pa_q, pa_d;
    logic [1:0]  fault_q, fault_d;

    logic [TLB_ENTRIES-1:0][19:0] page_q;
    logic [TLB_ENTRIES-1:0][17:0] frame_q;
    logic [TLB_ENTRIES-1:0]       wrt_q;
    logic [TLB_ENTRIES-1:0]       vld_q;
    logic [TLB_ENTRIES-1:0]       match;

    // Matching ignores the valid flag so an invalid hit can be reported as its own fault.
    for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_entry
        assign match[g] = (page_q[g] == va_q[31:12]);

        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                page_q[g]  <= '0;
                frame_q[g] <= '0;
                wrt_q[g]   <= 1'b0;
                vld_q[g]   <= 1'b0;
            end else if (tlbWriteEnable && tlbWriteIndex == 5'(g)) begin
                page_q[g]  <= tlbWritePage;
                frame_q[g] <= tlbWriteFrame;
                wrt_q[g]   <= tlbWriteWritable;
                vld_q[g]   <= tlbWriteValid;
            end
        end
    end

    logic        hit, hit_w, hit_v;
    logic [17:0] hit_frame;
    logic [31:0] lk_pa;
    logic [1:0]  lk_fault;

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        hit       = 1'b0;
        hit_w     = 1'b0;
        hit_v     = 1'b0;
        hit_frame = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit       = 1'b1;
                hit_w     = wrt_q[i];
                hit_v     = vld_q[i];
                hit_frame = frame_q[i];
            end
        end

        lk_pa    = '0;
        lk_fault = FLT_NONE;
        if (va_q[31:30] == 2'b11) begin
            lk_pa = {2'b00, va_q[29:0]};
        end else if (!hit) begin
            lk_fault = FLT_MISS;
        end else if (!hit_v) begin
            lk_fault = FLT_INVALID;
        end else if (wr_q && !hit_w) begin
            lk_fault = FLT_WPROT;
        end else begin
            lk_pa = {2'b00, hit_frame, va_q[11:0]};
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            va_q    <= '0;
            wr_q    <= 1'b0;
            pa_q    <= '0;
            fault_q <= FLT_NONE;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            wr_q    <= wr_d;
            pa_q    <= pa_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        va_d          = va_q;
        wr_d          = wr_q;
        pa_d          = pa_q;
        fault_d       = fault_q;
        requestReady  = 1'b0;
        responseValid = 1'b0;
        case (state_q)
            IDLE: begin
                requestReady = 1'b1;
                if (requestValid) begin
                    va_d    = virtualAddress;
                    wr_d    = requestWrite;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                pa_d    = lk_pa;
                fault_d = lk_fault;
                state_d = RESPOND;
            end
            RESPOND: begin
                responseValid = 1'b1;
                if (responseReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign physicalAddress = pa_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_mmu_address_translator.sv
// Directed bench for mmu_address_translator: direct map, TLB hit/miss/faults,
// lowest-index priority, write/lookup ordering, backpressure and mid-transaction reset.
module tb_mmu_address_translator;

    logic        clock = 1'b0;
    logic        resetN;
    logic        requestValid, requestReady;
    logic [31:0] virtualAddress;
    logic        requestWrite;
    logic        responseValid, responseReady;
    logic [31:0] physicalAddress;
    logic [1:0]  fault;
    logic        tlbWriteEnable;
    logic [4:0]  tlbWriteIndex;
    logic [19:0] tlbWritePage;
    logic [17:0] tlbWriteFrame;
    logic        tlbWriteWritable, tlbWriteValid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mmu_address_translator #(.TLB_ENTRIES(32)) dut (
        .clock            (clock),
        .resetN           (resetN),
        .requestValid     (requestValid),
        .requestReady     (requestReady),
        .virtualAddress   (virtualAddress),
        .requestWrite     (requestWrite),
        .responseValid    (responseValid),
        .responseReady    (responseReady),
        .physicalAddress  (physicalAddress),
        .fault            (fault),
        .tlbWriteEnable   (tlbWriteEnable),
        .tlbWriteIndex    (tlbWriteIndex),
        .tlbWritePage     (tlbWritePage),
        .tlbWriteFrame    (tlbWriteFrame),
        .tlbWriteWritable (tlbWriteWritable),
        .tlbWriteValid    (tlbWriteValid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tlb_write(input logic [4:0] idx, input logic [19:0] page,
                             input logic [17:0] frame, input logic w, input logic v);
        @(negedge clock);
        tlbWriteEnable   = 1'b1;
        tlbWriteIndex    = idx;
        tlbWritePage     = page;
        tlbWriteFrame    = frame;
        tlbWriteWritable = w;
        tlbWriteValid    = v;
        @(negedge clock);
        tlbWriteEnable   = 1'b0;
    endtask

    task automatic translate(input string tag, input logic [31:0] va, input logic wr,
                             input logic [31:0] exp_pa, input logic [1:0] exp_f);
        @(negedge clock);
        check({tag, ".rdy"}, requestReady, 1);
        requestValid   = 1'b1;
        virtualAddress = va;
        requestWrite   = wr;
        @(posedge clock); #1;
        requestValid = 1'b0;
        check({tag, ".lkvld"}, responseValid, 0);
        @(posedge clock); #1;
        check({tag, ".vld"}, responseValid, 1);
        check({tag, ".pa"}, physicalAddress, exp_pa);
        check({tag, ".flt"}, fault, exp_f);
        responseReady = 1'b1;
        @(posedge clock); #1;
        responseReady = 1'b0;
        check({tag, ".done_vld"}, responseValid, 0);
        check({tag, ".done_rdy"}, requestReady, 1);
    endtask

    initial begin
        resetN = 1'b0;
        requestValid = 1'b0; virtualAddress = '0; requestWrite = 1'b0; responseReady = 1'b0;
        tlbWriteEnable = 1'b0; tlbWriteIndex = '0; tlbWritePage = '0; tlbWriteFrame = '0;
        tlbWriteWritable = 1'b0; tlbWriteValid = 1'b0;
        #1;
        check("rst.rdy", requestReady, 1);
        check("rst.vld", responseValid, 0);
        check("rst.pa", physicalAddress, 0);
        check("rst.flt", fault, 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;

        // Direct-mapped window and its boundary
        translate("dm1", 32'hC0012345, 1'b0, 32'h00012345, 2'd0);
        translate("dm_wr", 32'hC0000000, 1'b1, 32'h00000000, 2'd0);
        translate("dm_top", 32'hFFFFFFFF, 1'b0, 32'h3FFFFFFF, 2'd0);
        translate("bnd", 32'hBFFFFFFF, 1'b0, 32'h00000000, 2'd1);

        // Cleared TLB: miss, and page 0 matches every (invalid) entry
        translate("miss", 32'h00401000, 1'b0, 32'h00000000, 2'd1);
        translate("pg0", 32'h00000ABC, 1'b0, 32'h00000000, 2'd2);

        tlb_write(5'd3, 20'h00401, 18'h00ABC, 1'b1, 1'b1);
        translate("hit_rd", 32'h00401234, 1'b0, 32'h00ABC234, 2'd0);
        translate("hit_wr", 32'h00401234, 1'b1, 32'h00ABC234, 2'd0);
        tlb_write(5'd3, 20'h00401, 18'h00ABC, 1'b0, 1'b1);
        translate("wprot", 32'h00401234, 1'b1, 32'h00000000, 2'd3);
        translate("ro_rd", 32'h00401234, 1'b0, 32'h00ABC234, 2'd0);
        tlb_write(5'd3, 20'h00401, 18'h00ABC, 1'b0, 1'b0);
        translate("inval", 32'h00401234, 1'b1, 32'h00000000, 2'd2);

        tlb_write(5'd7, 20'h12345, 18'h00111, 1'b1, 1'b1);
        tlb_write(5'd2, 20'h12345, 18'h00222, 1'b1, 1'b1);
        translate("multi", 32'h12345008, 1'b0, 32'h00222008, 2'd0);
        tlb_write(5'd2, 20'h12345, 18'h00222, 1'b1, 1'b0);
        translate("multi_inv", 32'h12345008, 1'b0, 32'h00000000, 2'd2);

        // A write landing on the edge that leaves LOOKUP must not change that result
        tlb_write(5'd5, 20'h0ABCD, 18'h00555, 1'b1, 1'b1);
        @(negedge clock);
        requestValid = 1'b1; virtualAddress = 32'h0ABCD010; requestWrite = 1'b0;
        @(posedge clock); #1;
        requestValid = 1'b0;
        tlbWriteEnable = 1'b1; tlbWriteIndex = 5'd5; tlbWritePage = 20'h0ABCD;
        tlbWriteFrame = 18'h00555; tlbWriteWritable = 1'b1; tlbWriteValid = 1'b0;
        @(posedge clock); #1;
        tlbWriteEnable = 1'b0;
        check("race.vld", responseValid, 1);
        check("race.pa", physicalAddress, 32'h00555010);
        check("race.flt", fault, 0);
        responseReady = 1'b1;
        @(posedge clock); #1;
        responseReady = 1'b0;
        translate("race_after", 32'h0ABCD010, 1'b0, 32'h00000000, 2'd2);

        // Backpressure: result held, new request ignored until release
        @(negedge clock);
        requestValid = 1'b1; virtualAddress = 32'hC0ABCDEF; requestWrite = 1'b0;
        @(posedge clock); #1;
        virtualAddress = 32'hC0000042;
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp.vld", responseValid, 1);
            check("bp.pa", physicalAddress, 32'h00ABCDEF);
            check("bp.flt", fault, 0);
            check("bp.rdy", requestReady, 0);
            @(posedge clock); #1;
        end
        responseReady = 1'b1;
        @(posedge clock); #1;
        responseReady = 1'b0;
        check("bp.rel_rdy", requestReady, 1);
        check("bp.rel_vld", responseValid, 0);
        check("bp.rel_pa", physicalAddress, 32'h00ABCDEF);
        @(posedge clock); #1;
        requestValid = 1'b0;
        check("bp.acc_rdy", requestReady, 0);
        check("bp.acc_vld", responseValid, 0);
        @(posedge clock); #1;
        check("bp2.vld", responseValid, 1);
        check("bp2.pa", physicalAddress, 32'h00000042);
        responseReady = 1'b1;
        @(posedge clock); #1;
        responseReady = 1'b0;

        // Asynchronous reset in the middle of LOOKUP
        @(negedge clock);
        requestValid = 1'b1; virtualAddress = 32'hC0000777; requestWrite = 1'b0;
        @(posedge clock); #1;
        requestValid = 1'b0;
        check("mr.lk_rdy", requestReady, 0);
        #2 resetN = 1'b0;
        #1;
        check("mr.rdy", requestReady, 1);
        check("mr.vld", responseValid, 0);
        check("mr.pa", physicalAddress, 0);
        check("mr.flt", fault, 0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("mr.post_vld", responseValid, 0);
        end
        translate("mr_tlb", 32'h00401234, 1'b0, 32'h00000000, 2'd1);
        translate("mr_pg0", 32'h00000ABC, 1'b0, 32'h00000000, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
